// File: rtl/sample_feeder13_if.sv
// Sample element type and the upstream sample handshake bundle for sample_feeder13.
package sample_feeder13_pkg;
    // Unsigned fraction in [0,1): value = code / 256, so 8'h80 is 0.5.
    typedef logic [7:0] zero2one_t;
endpackage

interface sample_feeder13_if #(
    parameter int N = 16,
    parameter int M = 13
);
    import sample_feeder13_pkg::*;

    logic                  s_valid;
    logic                  s_ready;
    logic                  s_learn;
    zero2one_t [N-1:0]     s_in;
    zero2one_t [M-1:0]     s_expected;

    modport master (output s_valid, s_learn, s_in, s_expected, input s_ready);
    modport slave  (input s_valid, s_learn, s_in, s_expected, output s_ready);
endinterface

// File: rtl/sample_feeder13.sv
// Queues training samples and issues them to the learning layer one at a time, SETTLE idle cycles apart.
// Optional SAMPLE_FEEDER_STATS_EN adds saturating issued/learn pulse counters.
module sample_feeder13
    import sample_feeder13_pkg::*;
#(
    parameter int N      = 16,
    parameter int M      = 13,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    sample_feeder13_if.slave        s,
    input  logic                    flush,
    output logic                    valid,
    output logic                    learn,
    output zero2one_t [N-1:0]       in,
    output zero2one_t [M-1:0]       expected_out,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  level
`ifdef SAMPLE_FEEDER_STATS_EN
    ,
    output logic [15:0]             issued_count,
    output logic [15:0]             learn_count
`endif
);
    localparam int               AW        = $clog2(DEPTH);
    localparam logic [AW:0]      FULL      = DEPTH[AW:0];
    localparam logic [3:0]       WAIT_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    typedef struct packed {
        logic              lrn;
        zero2one_t [N-1:0] vec;
        zero2one_t [M-1:0] tgt;
    } sample_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    sample_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    state_t          state, state_nxt;
    logic [3:0]      wait_cnt, wait_cnt_nxt;
    logic            lrn_q;
    logic            push, pop;

    // Ready looks only at registered occupancy, so a full FIFO refuses even while popping.
    assign s.s_ready = (level != FULL) && !flush && !reset;
    assign push      = s.s_valid && s.s_ready;
    assign busy      = (level != '0) || (state != IDLE);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        pop          = 1'b0;
        valid        = 1'b0;
        learn        = 1'b0;
        case (state)
            IDLE: if (level != '0 && !flush) begin
                pop       = 1'b1;
                state_nxt = ISSUE;
            end
            ISSUE: begin
                valid        = 1'b1;
                learn        = lrn_q;
                wait_cnt_nxt = '0;
                state_nxt    = (SETTLE > 0) ? WAIT : IDLE;
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) state_nxt = IDLE;
                else                       wait_cnt_nxt = wait_cnt + 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt    = IDLE;
            wait_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= '{lrn: s.s_learn, vec: s.s_in, tgt: s.s_expected};
    end

    // Issued vectors are held until the next pop; flush leaves them alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            lrn_q        <= 1'b0;
            in           <= '0;
            expected_out <= '0;
        end else if (pop) begin
            lrn_q        <= mem[rd_ptr].lrn;
            in           <= mem[rd_ptr].vec;
            expected_out <= mem[rd_ptr].tgt;
        end
    end

`ifdef SAMPLE_FEEDER_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            issued_count <= '0;
            learn_count  <= '0;
        end else begin
            if (valid && issued_count != 16'hFFFF) issued_count <= issued_count + 16'd1;
            if (learn && learn_count  != 16'hFFFF) learn_count  <= learn_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sample_feeder13.sv
// Randomized bench for sample_feeder13 against a queue-and-schedule reference model.
module tb_sample_feeder13;
    import sample_feeder13_pkg::*;

    localparam int N = 16, M = 13, DEPTH = 4, SETTLE = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic valid, learn, busy;
    zero2one_t [N-1:0] in_o;
    zero2one_t [M-1:0] exp_o;
    logic [$clog2(DEPTH):0] level;
`ifdef SAMPLE_FEEDER_STATS_EN
    logic [15:0] issued_count, learn_count;
`endif

    always #5 clock = ~clock;

    sample_feeder13_if #(.N(N), .M(M)) sif ();

    sample_feeder13 #(.N(N), .M(M), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clock(clock), .reset(reset), .s(sif.slave), .flush(flush),
        .valid(valid), .learn(learn), .in(in_o), .expected_out(exp_o),
        .busy(busy), .level(level)
`ifdef SAMPLE_FEEDER_STATS_EN
        , .issued_count(issued_count), .learn_count(learn_count)
`endif
    );

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: a sample queue plus an issue schedule in absolute cycle numbers.
    typedef struct {
        logic             l;
        logic [N*8-1:0]   v;
        logic [M*8-1:0]   t;
    } smp_t;

    smp_t q[$];
    smp_t last;
    int   cyc       = 0;
    int   idle_from = 0;   // first cycle the feeder may pop again
    int   issue_cyc = -1;  // cycle carrying the most recent valid pulse
    int   m_iss = 0, m_lrn = 0;

    task automatic step(input bit v, input bit l, input bit fl, input bit rs, input bit half);
        smp_t nw;
        bit   vexp;
        @(negedge clock);
        vexp = (cyc == issue_cyc);
        chk("valid", valid, vexp);
        chk("learn", learn, vexp & last.l);
        chk("in", in_o, last.v);
        chk("expected_out", exp_o, last.t);
        chk("level", level, q.size());
        chk("busy", busy, (q.size() > 0) || (cyc < idle_from));
`ifdef SAMPLE_FEEDER_STATS_EN
        chk("issued_count", issued_count, m_iss);
        chk("learn_count", learn_count, m_lrn);
`endif
        nw.l = l;
        for (int i = 0; i < N; i++) nw.v[i*8 +: 8] = half ? 8'h80 : 8'($urandom);
        for (int i = 0; i < M; i++) nw.t[i*8 +: 8] = 8'($urandom);
        sif.s_valid    = v;
        sif.s_learn    = l;
        sif.s_in       = nw.v;
        sif.s_expected = nw.t;
        flush          = fl;
        reset          = rs;
        #1;
        chk("s_ready", sif.s_ready, (q.size() != DEPTH) && !fl && !rs);
        if (rs) begin
            q.delete();
            last      = '{default: '0};
            idle_from = cyc + 1;
            issue_cyc = -1;
            m_iss     = 0;
            m_lrn     = 0;
        end else begin
            if (vexp && m_iss < 16'hFFFF) m_iss++;
            if (vexp && last.l && m_lrn < 16'hFFFF) m_lrn++;
            if (fl) begin
                q.delete();
                idle_from = cyc + 1;
            end else begin
                bit push_now = v && (q.size() != DEPTH);
                if (q.size() > 0 && cyc >= idle_from) begin
                    last      = q.pop_front();
                    issue_cyc = cyc + 1;
                    idle_from = cyc + SETTLE + 2;
                end
                if (push_now) q.push_back(nw);
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        sif.s_valid    = 1'b0;
        sif.s_learn    = 1'b0;
        sif.s_in       = '0;
        sif.s_expected = '0;
        last           = '{default: '0};
        repeat (2) @(posedge clock);

        // single half-scale learn sample after reset
        step(0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 1);
        idle(6);
        // four back-to-back pushes
        for (int i = 0; i < 4; i++) step(1, i[0], 0, 0, 0);
        idle(16);
        // six continuous pushes into a 4-deep FIFO
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0);
        idle(30);
        // non-learn sample
        step(1, 0, 0, 0, 0);
        idle(5);
        // queue three, flush while waiting, then reset mid-issue
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        idle(2);
        step(0, 0, 1, 0, 0);
        idle(5);
        step(1, 1, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 1, 0);
        idle(5);

        for (int i = 0; i < 1500; i++) begin
            bit burst = (i / 100) % 2 == 0;
            step(($urandom_range(0, 9) < (burst ? 8 : 3)),
                 1'($urandom),
                 ($urandom_range(0, 99) < 4),
                 ($urandom_range(0, 199) < 2),
                 ($urandom_range(0, 9) == 0));
        end
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sample_feeder13.md
SAMPLE_FEEDER13 -- requirements
Module: sample_feeder13

Interface
REQ-001 Parameter N, default 16, width of the input vector presented to the downstream 13-neuron learning layer.
REQ-002 Parameter M, default 13, number of expected-output lanes; fixed at 13 in this release.
REQ-003 Parameter DEPTH, default 4, sample FIFO depth; power of two, minimum 2.
REQ-004 Parameter SETTLE, default 2, idle cycles inserted after each issued sample; range 0..15.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 s_valid  input  1  upstream sample offered.
REQ-008 s_ready  output  1  feeder can accept a sample this cycle.
REQ-009 s_learn  input  1  per-sample learn flag.
REQ-010 s_in  input  zero2one_t[N]  sample input vector.
REQ-011 s_expected  input  zero2one_t[M]  sample target vector.
REQ-012 flush  input  1  discard all queued samples.
REQ-013 valid  output  1  one-cycle issue strobe to the layer.
REQ-014 learn  output  1  learn strobe to the layer; high only together with valid.
REQ-015 in  output  zero2one_t[N]  issued input vector.
REQ-016 expected_out  output  zero2one_t[M]  issued target vector.
REQ-017 busy  output  1  high when the FIFO is non-empty or the FSM is not IDLE.
REQ-018 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-019 Accept a sample on any rising edge where s_valid and s_ready are both high; store {s_learn, s_in, s_expected} at the FIFO tail.
REQ-020 s_ready = (level != DEPTH) and not flush; it is derived from registered level only, so a push into a full FIFO is refused even in a pop cycle.
REQ-021 FSM states: IDLE, ISSUE, WAIT.
REQ-022 IDLE with level>0: pop the head into the in/expected_out/learn registers; next state ISSUE.
REQ-023 ISSUE: valid=1 and learn=stored flag for exactly one cycle; next state WAIT if SETTLE>0, else IDLE.
REQ-024 WAIT: count SETTLE cycles with valid=0, then IDLE.
REQ-025 Latency: a sample pushed at edge t into an empty FIFO with FSM in IDLE produces valid during cycle t+2.
REQ-026 Back-to-back issue spacing is exactly SETTLE+2 cycles between valid pulses.
REQ-027 in and expected_out hold the last issued sample until the next pop.
REQ-028 A push and a pop in the same cycle leave level unchanged; FIFO pointers wrap modulo DEPTH.
REQ-029 flush, synchronously: FIFO emptied (level=0), FSM to IDLE, valid/learn low next cycle, in/expected_out retained; flush has priority over push and pop.

Reset
REQ-030 reset forces: FSM IDLE, level 0, pointers 0, valid 0, learn 0, in and expected_out all zero, busy 0, WAIT counter 0.
REQ-031 reset mid-ISSUE or mid-WAIT aborts immediately; no valid pulse follows reset until a new sample is pushed.
REQ-032 s_ready is 0 during reset and 1 in the first cycle after reset deasserts.

Configuration
REQ-033 Macro SAMPLE_FEEDER_STATS_EN, when defined, adds outputs issued_count (16-bit) and learn_count (16-bit): increment on each valid pulse and each learn pulse respectively, saturate at 0xFFFF, clear on reset only (not on flush).
REQ-034 Without SAMPLE_FEEDER_STATS_EN the ports and counters are absent; all other behaviour is identical.

Verification
REQ-035 Reset, push one sample (s_learn=1, s_in all 0.5) at cycle 0 -> valid=learn=1 at cycle 2 only, in all 0.5, level back to 0.
REQ-036 SETTLE=2, push 4 samples back-to-back -> s_ready stays high, 4 valid pulses at cycles 2,6,10,14 in push order.
REQ-037 DEPTH=4, push 6 samples continuously -> s_ready low once level=4; no sample lost or duplicated; order preserved.
REQ-038 Sample with s_learn=0 -> valid pulse with learn=0.
REQ-039 Queue 3 samples, assert flush during WAIT -> level=0, no further valid, busy low next cycle.
REQ-040 With SAMPLE_FEEDER_STATS_EN, issue 3 samples (2 learn) -> issued_count=3, learn_count=2; unchanged after flush, 0 after reset.
